alu_mdu: RTL and testbench
==========================

Name: alu_mdu

Overview:
- Execute-stage arithmetic unit for the pipelined RV32 core.
- Decodes ALUOp/funct3/funct7 into an extended ALU control code.
- Base-ISA ops complete in one cycle (combinational).
- RV32M multiply/divide/remainder ops run on an iterative datapath; the unit stalls the pipeline with a stall/valid handshake until the result is ready.

Parameters:
- WIDTH, 32, operand/result width in bits; must be even and at least 8.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- valid_i  in  1  an instruction is present in execute
- flush_i  in  1  kill the in-flight instruction
- ALUOp  in  2  00 = add (load/store), 01 = sub (branch), 10 = R-type, 11 = I-type
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- funct7b0  in  1  instruction bit 25 (M-extension select)
- opb5  in  1  opcode bit 5 (1 = R-type)
- a_i  in  WIDTH  operand A
- b_i  in  WIDTH  operand B
- alu_ctrl_o  out  5  decoded operation code
- result_o  out  WIDTH  result
- result_valid_o  out  1  result_o is valid this cycle
- stall_o  out  1  hold the pipeline; operands and control must stay stable

Behaviour:
- Decode for ALUOp 00/01 is ADD/SUB regardless of funct fields.
- Decode for ALUOp 1x is driven by funct3:
  - 000: SUB if opb5 & funct7b5, else ADD.
  - 001: SLL.
  - 010: SLT.
  - 011: SLTU.
  - 100: XOR.
  - 101: SRA if funct7b5, else SRL.
  - 110: OR.
  - 111: AND.
- If ALUOp = 10 and funct7b0 = 1, the op is M-type, selected by funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Decode never produces X.
- Shift amount is b_i[$clog2(WIDTH)-1:0].
- Base op with valid_i: result_o is combinational, result_valid_o = 1, stall_o = 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - valid_i & M-op & !flush_i: latch |a|, |b|, op and result sign; counter = WIDTH; stall_o = 1 (combinational); go to BUSY.
  - Exception: a special divide case (below) goes directly to DONE.
- BUSY:
  - One shift-add (multiply) or restoring shift-subtract (divide) step per cycle; counter decrements.
  - stall_o = 1, result_valid_o = 0.
  - When the counter reaches 1, go to DONE.
- DONE:
  - result_o comes from the register; result_valid_o = 1; stall_o = 0 for exactly one cycle; then IDLE.
  - Inputs are ignored in DONE (the same instruction is still presented).
- Latency: a normal M-op asserts stall_o for WIDTH+1 cycles; the result appears in cycle WIDTH+1 counted from first presentation (cycle 0).
- Signedness:
  - Operands are converted to magnitudes, with the sign taken per op (MULHSU: a signed, b unsigned).
  - The product is 2*WIDTH bits: MUL returns the low half, MULH/MULHSU/MULHU the high half.
  - The final negate is done in two's complement on the full width.
- Divide by zero: quotient = all ones; remainder = a_i. FSM goes IDLE→DONE, stall_o = 1 for one cycle.
- Signed overflow (a = -2^(WIDTH-1), b = -1): quotient = a_i, remainder = 0; same 1-cycle path.
- flush_i has priority in every state: stall_o = 0 and result_valid_o = 0 while asserted; FSM returns to IDLE next cycle; no result is produced.
- Reset (mid-operation included): state IDLE, counter 0, all datapath registers 0, stall_o = 0, result_valid_o = 0.
- result_o = 0 when not valid.

Decomposition:
- Package alu_pkg holds:
  - the 5-bit op codes (OP_ADD ... OP_REMU);
  - ALUOp encodings;
  - FSM state encodings;
  - helper is_mdu_op.
- Sub-module mdu_iter holds the iterative multiply/divide datapath and counter.
- alu_mdu itself holds the decode, the combinational base ALU and the FSM/handshake.

Test Plan:
- Base ops (WIDTH=32): ALUOp=10, funct3=000, opb5=1, funct7b5=1, a=5, b=7 -> SUB = 0xFFFFFFFE, valid the same cycle, stall_o = 0. Also ALUOp=11 with funct7b5=1, funct3=000 -> ADD = 12; funct3=011 with a=-1, b=1 -> SLTU = 0.
- MUL: a=7, b=-3 -> stall_o for 33 cycles, result 0xFFFFFFEB with result_valid_o in cycle 33. Also MULHU with a=b=0xFFFFFFFF -> 0xFFFFFFFE.
- DIV/REM: a=-7, b=2 -> DIV = -3 (0xFFFFFFFD), REM = -1. Also DIVU with a=0x80000000, b=2 -> 0x40000000.
- Divide specials: DIV a=9, b=0 -> 0xFFFFFFFF; REM -> 9; DIV a=0x80000000, b=-1 -> 0x80000000, REM 0. Each case shows 1 stall cycle.
- Flush: assert flush_i in BUSY cycle 10 -> stall_o drops that cycle, no result_valid_o; the next MUL 3*4 = 12 is correct with normal latency.
- Reset: drive reset_n = 0 in BUSY cycle 5 -> next cycle stall_o = 0, result_valid_o = 0, state IDLE; a fresh DIVU 100/7 -> 14.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: op codes, ALUOp encodings, FSM states and helpers shared by the execute unit
package alu_pkg;
    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    // M-extension codes are {2'b10, funct3} so the datapath can use the low bits directly
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    function automatic logic is_mdu_op(input logic [4:0] op);
        return op[4];
    endfunction
endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: iterative shift-add multiplier / restoring divider on operand magnitudes
module mdu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic             step_i,
    input  logic [2:0]       f3_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             special_o,
    output logic             last_o,
    output logic [WIDTH-1:0] result_o
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    // hi holds product-high / partial remainder, lo holds multiplier-then-product-low / dividend-then-quotient
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         f3_q, f3_d;
    logic               neg_q, neg_d;
    logic               sa, sb, div0, ovf;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, shl, diff;
    logic [2*WIDTH-1:0] prod, prod_s;

    // Operand prep, special-case detection and one iteration step
    always_comb begin
        sa        = (f3_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6}) & a_i[WIDTH-1];
        sb        = (f3_i inside {3'd0, 3'd1, 3'd4, 3'd6}) & b_i[WIDTH-1];
        a_mag     = sa ? -a_i : a_i;
        b_mag     = sb ? -b_i : b_i;
        div0      = f3_i[2] & (b_i == '0);
        ovf       = f3_i[2] & !f3_i[0] & (a_i == {1'b1, {(WIDTH-1){1'b0}}}) & (b_i == '1);
        special_o = div0 | ovf;
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shl       = {hi_q, lo_q[WIDTH-1]};
        diff      = shl - {1'b0, b_q};
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        f3_d      = f3_q;
        neg_d     = neg_q;
        if (start_i) begin
            f3_d  = f3_i;
            b_d   = b_mag;
            cnt_d = special_o ? '0 : CNT_W'(WIDTH);
            neg_d = special_o ? 1'b0 : (f3_i[2:1] == 2'b11) ? sa : sa ^ sb;
            hi_d  = div0 ? a_i : '0;
            lo_d  = div0 ? '1 : ovf ? a_i : a_mag;
        end else if (step_i) begin
            cnt_d = cnt_q - 1'b1;
            if (f3_q[2]) begin
                hi_d = diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], !diff[WIDTH]};
            end else begin
                {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
            end
        end
    end

    // Datapath registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            f3_q  <= '0;
            neg_q <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
            f3_q  <= f3_d;
            neg_q <= neg_d;
        end
    end

    // Sign fix-up in two's complement on the full width, then half/quotient/remainder select
    always_comb begin
        prod     = {hi_q, lo_q};
        prod_s   = neg_q ? -prod : prod;
        last_o   = (cnt_q == CNT_W'(1));
        result_o = (f3_q == 3'd0) ? prod_s[WIDTH-1:0] :
                   !f3_q[2]       ? prod_s[2*WIDTH-1:WIDTH] :
                   !f3_q[1]       ? (neg_q ? -lo_q : lo_q) :
                                    (neg_q ? -hi_q : hi_q);
    end
endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage decode, single-cycle base ALU and stall/valid handshake for M-ops
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_i,
    input  logic             flush_i,
    input  logic [1:0]       ALUOp,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             funct7b0,
    input  logic             opb5,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [4:0]       alu_ctrl_o,
    output logic [WIDTH-1:0] result_o,
    output logic             result_valid_o,
    output logic             stall_o
);
    localparam int SH_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic             mop, start, step, special, last;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] alu_res, mdu_res;

    // Decode ALUOp/funct fields into the extended op code
    always_comb begin
        alu_ctrl_o = OP_ADD;
        if (ALUOp == ALUOP_SUB) alu_ctrl_o = OP_SUB;
        else if (ALUOp == ALUOP_R && funct7b0) alu_ctrl_o = {2'b10, funct3};
        else if (ALUOp[1]) begin
            case (funct3)
                3'd0:    alu_ctrl_o = (opb5 & funct7b5) ? OP_SUB : OP_ADD;
                3'd1:    alu_ctrl_o = OP_SLL;
                3'd2:    alu_ctrl_o = OP_SLT;
                3'd3:    alu_ctrl_o = OP_SLTU;
                3'd4:    alu_ctrl_o = OP_XOR;
                3'd5:    alu_ctrl_o = funct7b5 ? OP_SRA : OP_SRL;
                3'd6:    alu_ctrl_o = OP_OR;
                default: alu_ctrl_o = OP_AND;
            endcase
        end
    end

    // Combinational base-ISA ALU
    always_comb begin
        shamt = b_i[SH_W-1:0];
        case (alu_ctrl_o)
            OP_ADD:  alu_res = a_i + b_i;
            OP_SUB:  alu_res = a_i - b_i;
            OP_SLL:  alu_res = a_i << shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a_i < b_i};
            OP_XOR:  alu_res = a_i ^ b_i;
            OP_SRL:  alu_res = a_i >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(a_i) >>> shamt);
            OP_OR:   alu_res = a_i | b_i;
            OP_AND:  alu_res = a_i & b_i;
            default: alu_res = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next state and handshake; flush and reset force the outputs quiet
    always_comb begin
        mop     = is_mdu_op(alu_ctrl_o);
        start   = reset_n & !flush_i & valid_i & mop & (state_q == S_IDLE);
        step    = !flush_i & (state_q == S_BUSY);
        state_d = state_q;
        if (flush_i) state_d = S_IDLE;
        else begin
            case (state_q)
                S_IDLE:  if (start) state_d = special ? S_DONE : S_BUSY;
                S_BUSY:  if (last) state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
        stall_o        = reset_n & !flush_i & ((state_q == S_BUSY) | ((state_q == S_IDLE) & valid_i & mop));
        result_valid_o = reset_n & !flush_i & ((state_q == S_DONE) | ((state_q == S_IDLE) & valid_i & !mop));
        result_o       = !result_valid_o ? '0 : (state_q == S_DONE) ? mdu_res : alu_res;
    end

    mdu_iter #(.WIDTH(WIDTH)) u_mdu (
        .clk       (clk),
        .reset_n   (reset_n),
        .start_i   (start),
        .step_i    (step),
        .f3_i      (alu_ctrl_o[2:0]),
        .a_i       (a_i),
        .b_i       (b_i),
        .special_o (special),
        .last_o    (last),
        .result_o  (mdu_res)
    );
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed vector table for base ops plus hand-written M-op, flush and reset sequences
module tb_alu_mdu;
    logic        clk = 1'b0;
    logic        reset_n, valid_i, flush_i, funct7b5, funct7b0, opb5;
    logic [1:0]  ALUOp;
    logic [2:0]  funct3;
    logic [31:0] a_i, b_i, result_o;
    logic [4:0]  alu_ctrl_o;
    logic        result_valid_o, stall_o;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [1:0]  aluop;
        logic [2:0]  f3;
        logic        b5;
        logic        b0;
        logic        op5;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  ctrl;
        logic [31:0] res;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    alu_mdu #(.WIDTH(32)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .valid_i        (valid_i),
        .flush_i        (flush_i),
        .ALUOp          (ALUOp),
        .funct3         (funct3),
        .funct7b5       (funct7b5),
        .funct7b0       (funct7b0),
        .opb5           (opb5),
        .a_i            (a_i),
        .b_i            (b_i),
        .alu_ctrl_o     (alu_ctrl_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .stall_o        (stall_o)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic present_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        valid_i  = 1'b1;
        ALUOp    = 2'b10;
        funct7b0 = 1'b1;
        funct7b5 = 1'b0;
        opb5     = 1'b1;
        funct3   = f3;
        a_i      = a;
        b_i      = b;
    endtask

    // Present an M-op, count stall cycles until result_valid_o, check value and one-cycle DONE
    task automatic run_mop(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_stalls);
        int          stalls = 0;
        bit          got = 0;
        logic [31:0] res = '0;
        logic        st_at_valid = 1'b1;
        present_mop(f3, a, b);
        #1;
        chk({name, "_ctrl"}, {27'd0, alu_ctrl_o}, {27'd0, 2'b10, f3});
        for (int c = 0; c < 100 && !got; c++) begin
            if (c != 0) #1;
            if (result_valid_o) begin
                got         = 1;
                res         = result_o;
                st_at_valid = stall_o;
            end else begin
                if (stall_o) stalls++;
                @(negedge clk);
            end
        end
        chk({name, "_got_valid"}, {31'd0, got}, 32'd1);
        chk({name, "_res"}, res, exp);
        chk({name, "_stalls"}, stalls, exp_stalls);
        chk({name, "_stall_at_valid"}, {31'd0, st_at_valid}, 32'd0);
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        chk({name, "_done_once"}, {31'd0, result_valid_o}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{2'b10, 3'd0, 1'b1, 1'b0, 1'b1, 32'd5, 32'd7, 5'd1, 32'hFFFFFFFE};
        vecs[1]  = '{2'b11, 3'd0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd7, 5'd0, 32'd12};
        vecs[2]  = '{2'b10, 3'd3, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1, 5'd4, 32'd0};
        vecs[3]  = '{2'b10, 3'd2, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1, 5'd3, 32'd1};
        vecs[4]  = '{2'b00, 3'd7, 1'b1, 1'b1, 1'b1, 32'd3, 32'd4, 5'd0, 32'd7};
        vecs[5]  = '{2'b01, 3'd5, 1'b0, 1'b1, 1'b1, 32'd3, 32'd4, 5'd1, 32'hFFFFFFFF};
        vecs[6]  = '{2'b11, 3'd1, 1'b0, 1'b0, 1'b0, 32'd1, 32'h25, 5'd2, 32'd32};
        vecs[7]  = '{2'b10, 3'd5, 1'b1, 1'b0, 1'b1, 32'h80000000, 32'd4, 5'd7, 32'hF8000000};
        vecs[8]  = '{2'b10, 3'd5, 1'b0, 1'b0, 1'b1, 32'h80000000, 32'd4, 5'd6, 32'h08000000};
        vecs[9]  = '{2'b10, 3'd4, 1'b0, 1'b0, 1'b1, 32'h0000F0F0, 32'h0000FF00, 5'd5, 32'h00000FF0};
        vecs[10] = '{2'b10, 3'd6, 1'b0, 1'b0, 1'b1, 32'h0000F0F0, 32'h0000FF00, 5'd8, 32'h0000FFF0};
        vecs[11] = '{2'b10, 3'd7, 1'b0, 1'b0, 1'b1, 32'h0000F0F0, 32'h0000FF00, 5'd9, 32'h0000F000};
        vecs[12] = '{2'b11, 3'd0, 1'b0, 1'b1, 1'b0, 32'd1, 32'd2, 5'd0, 32'd3};

        reset_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
        ALUOp = 2'b00; funct3 = 3'd0; funct7b5 = 1'b0; funct7b0 = 1'b0; opb5 = 1'b0;
        a_i = '0; b_i = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_valid", {31'd0, result_valid_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            ALUOp = vecs[i].aluop; funct3 = vecs[i].f3; funct7b5 = vecs[i].b5;
            funct7b0 = vecs[i].b0; opb5 = vecs[i].op5; a_i = vecs[i].a; b_i = vecs[i].b;
            valid_i = 1'b1;
            #1;
            chk($sformatf("vec%0d_ctrl", i), {27'd0, alu_ctrl_o}, {27'd0, vecs[i].ctrl});
            chk($sformatf("vec%0d_res", i), result_o, vecs[i].res);
            chk($sformatf("vec%0d_valid", i), {31'd0, result_valid_o}, 32'd1);
            chk($sformatf("vec%0d_stall", i), {31'd0, stall_o}, 32'd0);
            @(negedge clk);
        end
        valid_i = 1'b0;
        #1;
        chk("idle_result_zero", result_o, 32'd0);
        @(negedge clk);

        run_mop("mul", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        run_mop("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_mop("mulh", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        run_mop("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        run_mop("div", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        run_mop("rem", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        run_mop("divu", 3'd5, 32'h80000000, 32'd2, 32'h40000000, 33);
        run_mop("divu_nospecial", 3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33);
        run_mop("div0", 3'd4, 32'd9, 32'd0, 32'hFFFFFFFF, 1);
        run_mop("rem0", 3'd6, 32'd9, 32'd0, 32'd9, 1);
        run_mop("divu0", 3'd5, 32'd9, 32'd0, 32'hFFFFFFFF, 1);
        run_mop("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_mop("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);

        present_mop(3'd0, 32'd5, 32'd6);
        repeat (10) @(negedge clk);
        #1;
        chk("flush_pre_stall", {31'd0, stall_o}, 32'd1);
        flush_i = 1'b1;
        #1;
        chk("flush_stall", {31'd0, stall_o}, 32'd0);
        chk("flush_valid", {31'd0, result_valid_o}, 32'd0);
        @(negedge clk);
        flush_i = 1'b0;
        valid_i = 1'b0;
        #1;
        chk("flush_after_stall", {31'd0, stall_o}, 32'd0);
        chk("flush_after_valid", {31'd0, result_valid_o}, 32'd0);
        @(negedge clk);
        run_mop("mul_after_flush", 3'd0, 32'd3, 32'd4, 32'd12, 33);

        present_mop(3'd5, 32'd200, 32'd3);
        repeat (5) @(negedge clk);
        #1;
        chk("rst_pre_stall", {31'd0, stall_o}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_stall", {31'd0, stall_o}, 32'd0);
        chk("midrst_valid", {31'd0, result_valid_o}, 32'd0);
        chk("midrst_result", result_o, 32'd0);
        reset_n = 1'b1;
        valid_i = 1'b0;
        @(negedge clk);
        run_mop("divu_after_rst", 3'd5, 32'd100, 32'd7, 32'd14, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
